// File: rtl/tl_state_rr_arbiter.sv
// rtl/tl_state_rr_arbiter.sv - round-robin arbiter feeding one TileLink state holding register
module tl_state_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   in_valid,
    output logic [N_REQ-1:0]   in_ready,
    input  logic [4*N_REQ-1:0] in_size,
    input  logic [5*N_REQ-1:0] in_source,
    input  logic [N_REQ-1:0]   in_extra_id,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [3:0]         out_size,
    output logic [4:0]         out_source,
    output logic               out_extra_id,
    output logic [IDX_W-1:0]   out_idx
);

    logic             full_q, full_d;
    logic [3:0]       size_q, size_d;
    logic [4:0]       source_q, source_d;
    logic             extra_q, extra_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] win_idx;
    logic             found;
    logic [3:0]       win_size;
    logic [4:0]       win_source;
    logic             win_extra;
    logic             can_take;
    logic             enq;
    logic             deq;
    int               cand;

    // Scan upward from the priority pointer, wrapping at N_REQ.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && in_valid[IDX_W'(cand)]) begin
                found               = 1'b1;
                win_idx             = IDX_W'(cand);
                grant[IDX_W'(cand)] = 1'b1;
            end
        end
    end

    always_comb begin
        win_size   = '0;
        win_source = '0;
        win_extra  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_size   = in_size[4*i +: 4];
                win_source = in_source[5*i +: 5];
                win_extra  = in_extra_id[i];
            end
        end
    end

    assign can_take = ~full_q | out_ready;
    assign in_ready = grant & {N_REQ{can_take}};
    assign enq      = found & can_take;
    assign deq      = full_q & out_ready;

    always_comb begin
        full_d   = full_q;
        size_d   = size_q;
        source_d = source_q;
        extra_d  = extra_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        if (enq) begin
            full_d   = 1'b1;
            size_d   = win_size;
            source_d = win_source;
            extra_d  = win_extra;
            idx_d    = win_idx;
            // Explicit wrap keeps non-power-of-two N_REQ in range.
            ptr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else if (deq) begin
            full_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q   <= 1'b0;
            size_q   <= '0;
            source_q <= '0;
            extra_q  <= 1'b0;
            idx_q    <= '0;
            ptr_q    <= '0;
        end else begin
            full_q   <= full_d;
            size_q   <= size_d;
            source_q <= source_d;
            extra_q  <= extra_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
        end
    end

    assign out_valid    = full_q;
    assign out_size     = size_q;
    assign out_source   = source_q;
    assign out_extra_id = extra_q;
    assign out_idx      = idx_q;

endmodule

// File: tb/tb_tl_state_rr_arbiter.sv
// tb/tb_tl_state_rr_arbiter.sv - self-checking bench for tl_state_rr_arbiter
module tb_tl_state_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [4*N-1:0] in_size = '0;
    logic [5*N-1:0] in_source = '0;
    logic [N-1:0]   in_extra_id = '0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [3:0]     out_size;
    logic [4:0]     out_source;
    logic           out_extra_id;
    logic [IW-1:0]  out_idx;

    tl_state_rr_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_size      (in_size),
        .in_source    (in_source),
        .in_extra_id  (in_extra_id),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_size     (out_size),
        .out_source   (out_source),
        .out_extra_id (out_extra_id),
        .out_idx      (out_idx)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one-slot store plus priority pointer as plain integers.
    int         m_ptr  = 0;
    bit         m_full = 1'b0;
    logic [3:0] m_size = '0;
    logic [4:0] m_src  = '0;
    logic       m_x    = 1'b0;
    int         m_idx  = 0;

    // Per-requester pending offers used by the random phase.
    logic [3:0] r_sz [N];
    logic [4:0] r_src[N];
    logic       r_x  [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_full = 1'b0; m_size = '0; m_src = '0; m_x = 1'b0; m_idx = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/out_valid"},    32'(out_valid),    32'(m_full));
        check({tag, "/out_size"},     32'(out_size),     32'(m_size));
        check({tag, "/out_source"},   32'(out_source),   32'(m_src));
        check({tag, "/out_extra_id"}, 32'(out_extra_id), 32'(m_x));
        check({tag, "/out_idx"},      32'(out_idx),      32'(m_idx));
    endtask

    // Entered just after a negedge with inputs applied; returns the accepted requester or -1.
    task automatic cycle(input string tag, output int acc);
        int         w;
        bit         can;
        logic [N-1:0] er;
        #1;
        w   = model_winner();
        can = !m_full || out_ready;
        er  = '0;
        if (w >= 0 && can) er[w] = 1'b1;
        check({tag, "/in_ready"}, 32'(in_ready), 32'(er));
        acc = (w >= 0 && can) ? w : -1;
        @(posedge clock);
        if (acc >= 0) begin
            m_full = 1'b1;
            m_size = 4'(in_size >> (4 * acc));
            m_src  = 5'(in_source >> (5 * acc));
            m_x    = in_extra_id[acc];
            m_idx  = acc;
            m_ptr  = (acc + 1) % N;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
        #1;
        check_outputs(tag);
        @(negedge clock);
    endtask

    task automatic pack_offers();
        for (int i = 0; i < N; i++) begin
            in_size[4*i +: 4]   = r_sz[i];
            in_source[5*i +: 5] = r_src[i];
            in_extra_id[i]      = r_x[i];
        end
    endtask

    task automatic randomize_offer(input int i);
        r_sz[i]  = 4'($urandom);
        r_src[i] = 5'($urandom);
        r_x[i]   = 1'($urandom);
    endtask

    initial begin
        int acc;
        int seen[N];

        for (int i = 0; i < N; i++) randomize_offer(i);
        pack_offers();

        // Reset state, with ready following grant logic at can_take=1.
        in_valid = 4'b1010;
        @(negedge clock);
        #1;
        check_outputs("reset");
        check("reset/in_ready", 32'(in_ready), 32'(4'b0010));
        in_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;

        // Single requester 2.
        r_sz[2] = 4'h6; r_src[2] = 5'h13; r_x[2] = 1'b1;
        pack_offers();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        cycle("single", acc);
        check("single/idx_const",  32'(out_idx),    32'd2);
        check("single/size_const", 32'(out_size),   32'h6);
        check("single/src_const",  32'(out_source), 32'h13);

        // Pointer at 3: reqs 1 and 3 valid -> 3 wins, then 1.
        randomize_offer(1); randomize_offer(3); pack_offers();
        in_valid = 4'b1010;
        cycle("wrap_a", acc);
        check("wrap_a/winner", 32'(out_idx), 32'd3);
        in_valid = 4'b0010;
        cycle("wrap_b", acc);
        check("wrap_b/winner", 32'(out_idx), 32'd1);

        // Drain with nothing offered.
        in_valid = '0;
        cycle("drain", acc);
        check("drain/out_valid_const", 32'(out_valid), 32'd0);

        // Pointer must still be 2 after the drain.
        in_valid = 4'b1111;
        cycle("after_drain", acc);
        check("after_drain/winner", 32'(out_idx), 32'd2);

        // Asynchronous reset mid-cycle while full.
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Round robin: eight back-to-back accepts from ptr 0.
        for (int k = 0; k < 8; k++) begin
            cycle($sformatf("rr%0d", k), acc);
            check($sformatf("rr%0d/seq", k), 32'(out_idx), 32'(k % N));
            check($sformatf("rr%0d/vld", k), 32'(out_valid), 32'd1);
        end

        // Backpressure for five cycles, then release.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle($sformatf("bp%0d", k), acc);
            check($sformatf("bp%0d/idx_hold", k), 32'(out_idx), 32'd3);
        end
        out_ready = 1'b1;
        cycle("bp_release", acc);
        check("bp_release/winner", 32'(out_idx), 32'd0);
        check("bp_release/vld", 32'(out_valid), 32'd1);

        // Fairness: every requester exactly once in each window of N accepts.
        for (int i = 0; i < N; i++) seen[i] = 0;
        for (int k = 0; k < 3 * N; k++) begin
            cycle("fair", acc);
            if (acc >= 0) seen[acc]++;
        end
        for (int i = 0; i < N; i++) check($sformatf("fair/req%0d", i), 32'(seen[i]), 32'd3);

        // Random traffic; offers are held until accepted.
        in_valid = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    randomize_offer(i);
                    in_valid[i] = 1'b1;
                end
            end
            pack_offers();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand", acc);
            if (acc >= 0) in_valid[acc] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
